// File: rtl/hovalaag_cpu.sv
// hovalaag_cpu: single-cycle 12-bit core driven by 32-bit horizontal microcode.
// Every instruction is decoded, executed and committed in one clock. The
// stream handshakes and the output port are combinational from the current
// instruction and the current architectural state.
module hovalaag_cpu (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] IN1,
  output logic        IN1_adv,
  input  logic [11:0] IN2,
  output logic        IN2_adv,
  output logic [11:0] OUT,
  output logic        OUT_valid,
  output logic        OUT_select,
  input  logic [31:0] instr,
  output logic [7:0]  PC_out
);

  // Architectural state
  logic [11:0] a, b, c, d, w;
  logic        f;
  logic [7:0]  pc;

  // Instruction fields
  logic [3:0]  alu_op;
  logic [1:0]  a_sel, b_sel, c_sel, w_sel, f_sel, pc_sel;
  logic        d_load, o_bit, i_bit, x_bit;
  logic [11:0] k;
  logic [7:0]  l;

  // ALU result and flag-out
  logic [11:0] r;
  logic        fo;
  logic [12:0] wide;

  // Next-state values
  logic [11:0] a_next, b_next, c_next, d_next, w_next;
  logic        f_next;
  logic [7:0]  pc_next, pc_inc;

  // Split the microcode word into its fields
  always_comb begin
    alu_op = instr[31:28];
    a_sel  = instr[27:26];
    b_sel  = instr[25:24];
    c_sel  = instr[23:22];
    d_load = instr[21];
    w_sel  = instr[20:19];
    f_sel  = instr[18:17];
    pc_sel = instr[16:15];
    o_bit  = instr[14];
    i_bit  = instr[13];
    x_bit  = instr[12];
    k      = instr[11:0];
    l      = instr[7:0];
  end

  // ALU: 13-bit intermediate keeps carry/borrow in bit 12
  always_comb begin
    r    = 12'd0;
    fo   = 1'b0;
    wide = 13'd0;
    case (alu_op)
      4'd0: begin r = a; fo = 1'b0; end
      4'd1: begin r = b; fo = 1'b0; end
      4'd2: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[11:0]; fo = wide[12];
      end
      4'd3: begin
        wide = {1'b0, a} + {1'b0, b} + {12'd0, f};
        r = wide[11:0]; fo = wide[12];
      end
      4'd4: begin
        wide = {1'b0, a} - {1'b0, b};
        r = wide[11:0]; fo = wide[12];
      end
      4'd5: begin
        wide = {1'b0, a} - {1'b0, b} - {12'd0, f};
        r = wide[11:0]; fo = wide[12];
      end
      4'd6: begin r = a & b; fo = (r == 12'd0); end
      4'd7: begin r = a | b; fo = (r == 12'd0); end
      4'd8: begin r = a ^ b; fo = (r == 12'd0); end
      4'd9: begin r = ~a;    fo = (r == 12'd0); end
      4'd10: begin r = {a[10:0], 1'b0}; fo = a[11]; end
      4'd11: begin r = {1'b0, a[11:1]}; fo = a[0]; end
      4'd12: begin r = {a[11], a[11:1]}; fo = a[0]; end
      4'd13: begin
        wide = {1'b0, b} - {1'b0, a};
        r = wide[11:0]; fo = wide[12];
      end
      4'd14: begin
        wide = {1'b0, a} + 13'd1;
        r = wide[11:0]; fo = wide[12];
      end
      4'd15: begin
        wide = {1'b0, a} - 13'd1;
        r = wide[11:0]; fo = wide[12];
      end
      default: begin r = 12'd0; fo = 1'b0; end
    endcase
  end

  // Register source selection; every source is a pre-edge value
  always_comb begin
    case (a_sel)
      2'd0:    a_next = a;
      2'd1:    a_next = r;
      2'd2:    a_next = c;
      2'd3:    a_next = d;
      default: a_next = a;
    endcase
    case (b_sel)
      2'd0:    b_next = b;
      2'd1:    b_next = r;
      2'd2:    b_next = i_bit ? IN2 : IN1;
      2'd3:    b_next = k;
      default: b_next = b;
    endcase
    case (c_sel)
      2'd0:    c_next = c;
      2'd1:    c_next = r;
      2'd2:    c_next = k;
      2'd3:    c_next = c - 12'd1;
      default: c_next = c;
    endcase
    if (d_load) begin
      d_next = r;
    end else begin
      d_next = d;
    end
    case (w_sel)
      2'd0:    w_next = w;
      2'd1:    w_next = r;
      2'd2:    w_next = a;
      2'd3:    w_next = b;
      default: w_next = w;
    endcase
    case (f_sel)
      2'd0:    f_next = f;
      2'd1:    f_next = fo;
      2'd2:    f_next = 1'b0;
      2'd3:    f_next = 1'b1;
      default: f_next = f;
    endcase
  end

  // Sequencer: branch conditions look at old F and old C
  always_comb begin
    pc_inc = pc + 8'd1;
    case (pc_sel)
      2'd0:    pc_next = pc_inc;
      2'd1:    pc_next = l;
      2'd2:    pc_next = (f == 1'b0) ? l : pc_inc;
      2'd3:    pc_next = (c != 12'd0) ? l : pc_inc;
      default: pc_next = pc_inc;
    endcase
  end

  // Port drive; strobes are masked while reset is held
  always_comb begin
    PC_out     = pc;
    OUT        = w_next;
    OUT_select = x_bit;
    OUT_valid  = o_bit & ~rst;
    IN1_adv    = (b_sel == 2'd2) & ~i_bit & ~rst;
    IN2_adv    = (b_sel == 2'd2) & i_bit & ~rst;
  end

  // State commit with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      a  <= 12'd0;
      b  <= 12'd0;
      c  <= 12'd0;
      d  <= 12'd0;
      w  <= 12'd0;
      f  <= 1'b0;
      pc <= 8'd0;
    end else begin
      a  <= a_next;
      b  <= b_next;
      c  <= c_next;
      d  <= d_next;
      w  <= w_next;
      f  <= f_next;
      pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_hovalaag_cpu.sv
// Directed testbench for hovalaag_cpu. The bench plays the role of the
// program ROM by driving instr directly, one word per clock.
module tb_hovalaag_cpu;

  logic        clk;
  logic        rst;
  logic [11:0] IN1, IN2;
  logic        IN1_adv, IN2_adv;
  logic [11:0] OUT;
  logic        OUT_valid, OUT_select;
  logic [31:0] instr;
  logic [7:0]  PC_out;

  int checks = 0;
  int errors = 0;

  hovalaag_cpu dut (
    .clk(clk), .rst(rst),
    .IN1(IN1), .IN1_adv(IN1_adv),
    .IN2(IN2), .IN2_adv(IN2_adv),
    .OUT(OUT), .OUT_valid(OUT_valid), .OUT_select(OUT_select),
    .instr(instr), .PC_out(PC_out)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build a microcode word from its fields
  function automatic logic [31:0] mk(
    input logic [3:0] alu, input logic [1:0] fa, input logic [1:0] fb,
    input logic [1:0] fc, input logic fd, input logic [1:0] fw,
    input logic [1:0] ff, input logic [1:0] fpc, input logic fo,
    input logic fi, input logic fx, input logic [11:0] k);
    mk = {alu, fa, fb, fc, fd, fw, ff, fpc, fo, fi, fx, k};
  endfunction

  // Present an instruction and let one edge execute it
  task automatic step(input logic [31:0] ins);
    instr = ins;
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and let comb outputs settle before the edge
  task automatic show(input logic [31:0] ins);
    instr = ins;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    IN1 = 12'd0; IN2 = 12'd0;
    // nonzero instruction: B<-IN1, W<-R, F set, O=1, jump
    instr = mk(4'd2, 2'd1, 2'd2, 2'd2, 1'b1, 2'd1, 2'd3, 2'd1, 1'b1, 1'b0, 1'b1, 12'h0A5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (PC_out !== 8'd0) begin errors++; $display("FAIL reset_pc got %h exp 00", PC_out); end
    checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", OUT_valid); end
    checks++; if (IN1_adv !== 1'b0 || IN2_adv !== 1'b0) begin errors++; $display("FAIL reset_adv got %b%b exp 00", IN1_adv, IN2_adv); end
    instr = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    // W keep: OUT shows W itself
    show(mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 12'd0));
    checks++; if (OUT !== 12'd0) begin errors++; $display("FAIL reset_w got %h exp 000", OUT); end
    // W <- B
    show(mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 12'd0));
    checks++; if (OUT !== 12'd0) begin errors++; $display("FAIL reset_b got %h exp 000", OUT); end
    // A <- C, then W <- A exposes C
    step(mk(4'd0, 2'd2, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0));
    show(mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd2, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 12'd0));
    checks++; if (OUT !== 12'd0) begin errors++; $display("FAIL reset_c got %h exp 000", OUT); end
    step(instr);
    checks++; if (PC_out !== 8'd2) begin errors++; $display("FAIL reset_pcrun got %h exp 02", PC_out); end
  endtask

  task automatic test_const_out;
    step(mk(4'd0, 2'd0, 2'd3, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 12'h09F));
    show(mk(4'd1, 2'd0, 2'd0, 2'd0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 12'd0));
    checks++; if (OUT !== 12'h09F) begin errors++; $display("FAIL const_out got %h exp 09F", OUT); end
    checks++; if (OUT_valid !== 1'b1 || OUT_select !== 1'b1) begin errors++; $display("FAIL const_flags got %b%b exp 11", OUT_valid, OUT_select); end
    step(instr);
  endtask

  task automatic test_alu;
    logic [3:0]  ops [7];
    logic [11:0] exps [7];
    ops  = '{4'd2, 4'd4, 4'd6, 4'd7, 4'd10, 4'd11, 4'd13};
    exps = '{12'd27, 12'd7, 12'd0, 12'd27, 12'd34, 12'd8, 12'hFF9};
    // B<-17; A<-B; B<-10 with F cleared
    step(mk(4'd0, 2'd0, 2'd3, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd17));
    step(mk(4'd1, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0));
    step(mk(4'd0, 2'd0, 2'd3, 2'd0, 1'b0, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 12'd10));
    for (int i = 0; i < 7; i++) begin
      show(mk(ops[i], 2'd0, 2'd0, 2'd0, 1'b0, 2'd1, (i == 6) ? 2'd1 : 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 12'd0));
      checks++;
      if (OUT !== exps[i]) begin errors++; $display("FAIL alu_op%0d got %h exp %h", ops[i], OUT, exps[i]); end
      step(instr);
    end
    // F=1 from the 10-17 borrow: A+B+F = 28
    show(mk(4'd3, 2'd0, 2'd0, 2'd0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 12'd0));
    checks++; if (OUT !== 12'd28) begin errors++; $display("FAIL alu_borrowflag got %h exp 01C", OUT); end
    step(instr);
  endtask

  task automatic test_carry;
    step(mk(4'd0, 2'd0, 2'd3, 2'd0, 1'b0, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 12'hFFF));
    step(mk(4'd1, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0));
    step(mk(4'd0, 2'd0, 2'd3, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd1));
    show(mk(4'd2, 2'd0, 2'd0, 2'd0, 1'b0, 2'd1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 12'd0));
    checks++; if (OUT !== 12'd0) begin errors++; $display("FAIL carry_sum got %h exp 000", OUT); end
    step(instr);
    step(mk(4'd0, 2'd0, 2'd3, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0));
    step(mk(4'd1, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0));
    show(mk(4'd3, 2'd0, 2'd0, 2'd0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 12'd0));
    checks++; if (OUT !== 12'd1) begin errors++; $display("FAIL carry_in got %h exp 001", OUT); end
    step(instr);
    // A-1 from 0 wraps to FFF
    show(mk(4'd15, 2'd0, 2'd0, 2'd0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 12'd0));
    checks++; if (OUT !== 12'hFFF) begin errors++; $display("FAIL dec_wrap got %h exp FFF", OUT); end
    step(instr);
  endtask

  task automatic test_input;
    IN1 = 12'd5; IN2 = 12'd9;
    show(mk(4'd0, 2'd0, 2'd2, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0));
    checks++; if (IN1_adv !== 1'b1 || IN2_adv !== 1'b0) begin errors++; $display("FAIL in1_adv got %b%b exp 10", IN1_adv, IN2_adv); end
    checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL in1_novalid got %b exp 0", OUT_valid); end
    step(instr);
    show(mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 12'd0));
    checks++; if (OUT !== 12'd5) begin errors++; $display("FAIL in1_value got %h exp 005", OUT); end
    step(instr);
    show(mk(4'd0, 2'd0, 2'd2, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 12'd0));
    checks++; if (IN1_adv !== 1'b0 || IN2_adv !== 1'b1) begin errors++; $display("FAIL in2_adv got %b%b exp 01", IN1_adv, IN2_adv); end
    step(instr);
    show(mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 12'd0));
    checks++; if (OUT !== 12'd9) begin errors++; $display("FAIL in2_value got %h exp 009", OUT); end
    step(instr);
  endtask

  task automatic test_branch;
    int n;
    step(mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 12'd3));
    checks++; if (PC_out !== 8'd3) begin errors++; $display("FAIL jump got %h exp 03", PC_out); end
    // C<-2 at PC 3; loop body at PC 4
    step(mk(4'd0, 2'd0, 2'd0, 2'd2, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd2));
    n = 0;
    while (PC_out == 8'd4 && n < 10) begin
      step(mk(4'd0, 2'd0, 2'd0, 2'd3, 1'b0, 2'd0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 12'd4));
      n++;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL loop_count got %0d exp 3", n); end
    checks++; if (PC_out !== 8'd5) begin errors++; $display("FAIL loop_exit got %h exp 05", PC_out); end
    step(mk(4'd0, 2'd2, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0));
    show(mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd2, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 12'd0));
    checks++; if (OUT !== 12'hFFF) begin errors++; $display("FAIL loop_c got %h exp FFF", OUT); end
    step(instr);
    // PC=7: set F; PC=8: jump-if-F-clear not taken
    step(mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0));
    step(mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 12'd100));
    checks++; if (PC_out !== 8'd9) begin errors++; $display("FAIL jf_nottaken got %h exp 09", PC_out); end
    // Clear F while jumping on old F (=1): falls through to 10
    step(mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 12'd100));
    checks++; if (PC_out !== 8'd10) begin errors++; $display("FAIL jf_oldflag got %h exp 0A", PC_out); end
    // Set F while jumping on old F (=0): taken
    step(mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd3, 2'd2, 1'b0, 1'b0, 1'b0, 12'd200));
    checks++; if (PC_out !== 8'd200) begin errors++; $display("FAIL jf_taken got %h exp C8", PC_out); end
    step(mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 12'd255));
    step(mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0));
    checks++; if (PC_out !== 8'd0) begin errors++; $display("FAIL pc_wrap got %h exp 00", PC_out); end
  endtask

  task automatic test_reset_mid;
    step(mk(4'd0, 2'd0, 2'd3, 2'd0, 1'b0, 2'd3, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 12'd77));
    checks++; if (PC_out !== 8'd77) begin errors++; $display("FAIL mid_pre got %h exp 4D", PC_out); end
    rst = 1'b1;
    show(mk(4'd0, 2'd0, 2'd2, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 12'd0));
    checks++; if (OUT_valid !== 1'b0 || IN1_adv !== 1'b0) begin errors++; $display("FAIL mid_mask got %b%b exp 00", OUT_valid, IN1_adv); end
    step(instr);
    rst = 1'b0;
    checks++; if (PC_out !== 8'd0) begin errors++; $display("FAIL mid_pc got %h exp 00", PC_out); end
    show(mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 12'd0));
    checks++; if (OUT !== 12'd0) begin errors++; $display("FAIL mid_w got %h exp 000", OUT); end
    step(instr);
  endtask

  initial begin
    instr = 32'd0;
    test_reset;
    test_const_out;
    test_alu;
    test_carry;
    test_input;
    test_branch;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
